seq_divider: RTL

- Sequential restoring divider. It is the inverse-operation companion to the shift-add multiplier.
- Takes an unsigned dividend and divisor on a start pulse and produces one quotient bit per clock.
- Presents quotient/remainder with a one-cycle done flag.
- Contains its own FSM, iteration counter and datapath. Sits beside the multiplier under the same arithmetic top level, with the same start/done/locked handshake.

---
 rtl/seq_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done/locked handshake.
// Ports: clk, rst (sync active-low), start, dividend, divisor -> quotient, remainder, done_flag, div_zero, locked, state.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done_flag,
   output logic             div_zero,
   output logic             locked,
   output logic [1:0]       state
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CALC   = 2'b01,
      FINISH = 2'b10
   } state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] count_q, count_n;
   logic [WIDTH-1:0] q_q, q_n;
   logic [WIDTH-1:0] d_q, d_n;
   // After each step the partial remainder is below the divisor, so it
   // always fits in WIDTH bits; only the shifted value needs WIDTH+1.
   logic [WIDTH-1:0] r_q, r_n;
   logic [WIDTH-1:0] quo_n, rem_n;
   logic             dz_n;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   t;

   always_comb begin
      state_n = state_q;
      count_n = count_q;
      q_n     = q_q;
      d_n     = d_q;
      r_n     = r_q;
      quo_n   = quotient;
      rem_n   = remainder;
      dz_n    = div_zero;
      r_sh    = {r_q, q_q[WIDTH-1]};
      t       = r_sh - {1'b0, d_q};
      case (state_q)
         IDLE: begin
            if (start) begin
               q_n     = dividend;
               d_n     = divisor;
               r_n     = '0;
               count_n = '0;
               if (divisor == '0) begin
                  state_n = FINISH;
                  quo_n   = '1;
                  rem_n   = dividend;
                  dz_n    = 1'b1;
               end else begin
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            if (!t[WIDTH]) begin
               r_n = t[WIDTH-1:0];
               q_n = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_n = r_sh[WIDTH-1:0];
               q_n = {q_q[WIDTH-2:0], 1'b0};
            end
            count_n = count_q + 1'b1;
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_n = FINISH;
               quo_n   = q_n;
               rem_n   = r_n;
               dz_n    = 1'b0;
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         q_q       <= '0;
         d_q       <= '0;
         r_q       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         state_q   <= state_n;
         count_q   <= count_n;
         q_q       <= q_n;
         d_q       <= d_n;
         r_q       <= r_n;
         quotient  <= quo_n;
         remainder <= rem_n;
         div_zero  <= dz_n;
      end
   end

   assign done_flag = (state_q == FINISH);
   assign locked    = (state_q == CALC);
   assign state     = state_q;

endmodule
